pending_decoder: RTL

Sequential N-to-2^N decoder that turns a stream of encoded line indices back into one-hot pulses and a sticky pending-line vector. It is the receive-side counterpart of the priority encoder: the encoder compresses an active line into a binary index, and this block re-expands each accepted index into its line, holding it pending until the consumer acknowledges it. It sits between an index-producing source and per-line consumers, with a valid/ready handshake on the input side.

---
 rtl/pending_decoder.sv | 105 ++++++++++
 1 files changed

// File: rtl/pending_decoder.sv
// pending_decoder
//   Receive-side expander for a stream of binary line indices. Each accepted
//   index becomes a one-cycle one-hot pulse and raises a sticky pending bit
//   that stays set until the consumer acknowledges that line.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-high reset
//   in_valid     : in_code carries an index this cycle
//   in_code      : binary index of the line to raise (N bits)
//   in_ready     : an index can be accepted (low only when every line pends)
//   ack          : per-line acknowledge, clears the matching pending bit
//   clr_ovf      : clears the overflow flag
//   onehot       : registered one-cycle pulse of the decoded line
//   onehot_valid : onehot carries a decode this cycle
//   pend         : sticky pending vector
//   pend_cnt     : population count of pend
//   ovf          : sticky flag, an index hit a line that was still pending
module pending_decoder #(
  parameter int N = 3,
  localparam int L = 1 << N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_code,
  output logic         in_ready,
  input  logic [L-1:0] ack,
  input  logic         clr_ovf,
  output logic [L-1:0] onehot,
  output logic         onehot_valid,
  output logic [L-1:0] pend,
  output logic [N:0]   pend_cnt,
  output logic         ovf
);

  localparam int CW = N + 1;

  logic [L-1:0] onehot_q, onehot_d;
  logic         onehot_valid_q, onehot_valid_d;
  logic [L-1:0] pend_q, pend_d;
  logic [N:0]   pend_cnt_q, pend_cnt_d;
  logic         ovf_q, ovf_d;

  logic         accept;
  logic [L-1:0] set_mask;
  logic         ovf_hit;

  function automatic logic [N:0] popcount(input logic [L-1:0] v);
    logic [N:0] c;
    c = '0;
    for (int i = 0; i < L; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Ready depends on registered pend only, so no combinational path from
  // the input side back to in_ready.
  assign in_ready = ~&pend_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    set_mask = '0;
    if (accept) begin
      set_mask[in_code] = 1'b1;
    end
  end

  // A re-hit on a line that is being acked in the same cycle is a fresh
  // event, not an overflow.
  assign ovf_hit = accept & pend_q[in_code] & ~ack[in_code];

  always_comb begin
    // Set is OR-ed in after the ack mask so a colliding set wins.
    pend_d         = (pend_q & ~ack) | set_mask;
    pend_cnt_d     = popcount(pend_d);
    onehot_d       = set_mask;
    onehot_valid_d = accept;
    ovf_d          = ovf_hit | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onehot_q       <= '0;
      onehot_valid_q <= 1'b0;
      pend_q         <= '0;
      pend_cnt_q     <= '0;
      ovf_q          <= 1'b0;
    end else begin
      onehot_q       <= onehot_d;
      onehot_valid_q <= onehot_valid_d;
      pend_q         <= pend_d;
      pend_cnt_q     <= pend_cnt_d;
      ovf_q          <= ovf_d;
    end
  end

  assign onehot       = onehot_q;
  assign onehot_valid = onehot_valid_q;
  assign pend         = pend_q;
  assign pend_cnt     = pend_cnt_q;
  assign ovf          = ovf_q;

endmodule
